// File: rtl/arb2_rr_sel.sv
// Two-requester round-robin arbiter driving the select of a 2:1 mux stage.
// Grants are held until done, a request drop, or the MAX_HOLD limit.
module arb2_rr_sel #(
  parameter int MAX_HOLD = 15,
  parameter int CW       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  output logic [1:0] grant,
  output logic       sel,
  output logic       busy,
  output logic       timeout
);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam int unsigned LIM_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CW-1:0] LIM = LIM_I[CW-1:0];

  state_t        r_state, w_state_nx;
  logic          r_last, w_last_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic          r_sel, w_sel_nx;
  logic          r_busy;
  logic          r_timeout, w_timeout_nx;

  logic          w_own;
  logic          w_norm;
  logic          w_force;
  logic          w_take;
  logic          w_pick;

  assign w_own   = (r_state == OWN1);
  assign w_norm  = done | ~req[w_own];
  assign w_force = (MAX_HOLD != 0) && (r_cnt == LIM) && !w_norm;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    w_state_nx   = r_state;
    w_last_nx    = r_last;
    w_cnt_nx     = r_cnt;
    w_sel_nx     = r_sel;
    w_timeout_nx = 1'b0;
    w_take       = 1'b0;
    w_pick       = 1'b0;

    case (r_state)
      OWN0, OWN1: begin
        if (w_norm || w_force) begin
          w_timeout_nx = w_force;
          if (req[~w_own]) begin
            w_take = 1'b1;
            w_pick = ~w_own;
          end else begin
            w_state_nx = IDLE;
          end
        end else if (r_cnt != '1) begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        if (req != 2'b00) begin
          w_take = 1'b1;
          w_pick = (req == 2'b11) ? ~r_last : req[1];
        end
      end
    endcase

    // Every ownership entry restarts the hold count; sel only moves here, so it holds while idle.
    if (w_take) begin
      w_state_nx = w_pick ? OWN1 : OWN0;
      w_last_nx  = w_pick;
      w_cnt_nx   = '0;
      w_sel_nx   = w_pick;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_cnt     <= '0;
      r_sel     <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_last    <= w_last_nx;
      r_cnt     <= w_cnt_nx;
      r_sel     <= w_sel_nx;
      r_busy    <= (w_state_nx != IDLE);
      r_timeout <= w_timeout_nx;
    end
  end

  assign grant   = r_state;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_arb2_rr_sel.sv
// Directed bench for arb2_rr_sel: a per-cycle behavioural model plus
// hand-computed expectations for each directed step.
module tb_arb2_rr_sel;

  localparam int MAX_HOLD = 4;
  localparam int CW       = 4;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic       done;
  logic [1:0] grant;
  logic       sel;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  arb2_rr_sel #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 = nobody), cycles the owner has held so far,
  // most recent winner, and the last-seen select and timeout pulse.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = 1;
  bit m_sel   = 1'b0;
  bit m_to    = 1'b0;

  task automatic model_grab(input int p);
    m_owner = p;
    m_last  = p;
    m_held  = 1;
    m_sel   = (p == 1);
  endtask

  task automatic model_step();
    int  n;
    bit  norm;
    bit  forced;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (req == 2'b11)      model_grab(1 - m_last);
      else if (req == 2'b01) model_grab(0);
      else if (req == 2'b10) model_grab(1);
    end else begin
      n      = m_owner;
      norm   = done || !req[n];
      forced = !norm && (MAX_HOLD != 0) && (m_held == MAX_HOLD);
      if (norm || forced) begin
        m_to = forced;
        if (req[1-n]) model_grab(1 - n);
        else          m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = 1;
      m_sel   = 1'b0;
      m_to    = 1'b0;
    end else begin
      model_step();
    end
    #1;
    check("model_grant",   {30'd0, grant}, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check("model_sel",     {31'd0, sel},     {31'd0, m_sel});
    check("model_busy",    {31'd0, busy},    (m_owner >= 0) ? 32'd1 : 32'd0);
    check("model_timeout", {31'd0, timeout}, {31'd0, m_to});
  end

  // Called at a falling edge: drive inputs, let one rising edge pass, then
  // compare against hand-computed values at the next falling edge.
  task automatic cyc(input logic [1:0] r, input logic d,
                     input logic [1:0] eg, input logic es, input logic et);
    req  = r;
    done = d;
    @(negedge clk);
    check("dir_grant",   {30'd0, grant},   {30'd0, eg});
    check("dir_sel",     {31'd0, sel},     {31'd0, es});
    check("dir_busy",    {31'd0, busy},    {31'd0, |eg});
    check("dir_timeout", {31'd0, timeout}, {31'd0, et});
  endtask

  initial begin
    rst  = 1'b1;
    req  = 2'b11;
    done = 1'b0;
    @(negedge clk);
    check("rst_grant",   {30'd0, grant},   32'd0);
    check("rst_sel",     {31'd0, sel},     32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    rst = 1'b0;

    // Source 0 wins first contention; done in its limit cycle hands over cleanly.
    cyc(2'b11, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(2'b11, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(2'b11, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(2'b11, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(2'b11, 1'b1, 2'b10, 1'b1, 1'b0);

    // Both requesting, no done: alternate every MAX_HOLD cycles with timeout pulses.
    cyc(2'b11, 1'b0, 2'b10, 1'b1, 1'b0);
    cyc(2'b11, 1'b0, 2'b10, 1'b1, 1'b0);
    cyc(2'b11, 1'b0, 2'b10, 1'b1, 1'b0);
    cyc(2'b11, 1'b0, 2'b01, 1'b0, 1'b1);
    cyc(2'b11, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(2'b11, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(2'b11, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(2'b11, 1'b0, 2'b10, 1'b1, 1'b1);

    // Owner 1 drops its request: immediate switch to 0, no timeout.
    cyc(2'b01, 1'b0, 2'b01, 1'b0, 1'b0);

    // Lone requester hits the limit: one idle cycle with timeout, then re-wins.
    cyc(2'b01, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 2'b00, 1'b0, 1'b1);
    cyc(2'b01, 1'b0, 2'b01, 1'b0, 1'b0);

    // done releases to idle; done while idle is ignored; sel holds while idle.
    cyc(2'b01, 1'b1, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 1'b1, 2'b00, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 2'b10, 1'b1, 1'b0);
    cyc(2'b00, 1'b0, 2'b00, 1'b1, 1'b0);
    cyc(2'b11, 1'b0, 2'b01, 1'b0, 1'b0);
    cyc(2'b11, 1'b1, 2'b10, 1'b1, 1'b0);

    // Asynchronous reset mid-OWN1, between clock edges.
    done = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_grant",   {30'd0, grant},   32'd0);
    check("arst_sel",     {31'd0, sel},     32'd0);
    check("arst_busy",    {31'd0, busy},    32'd0);
    check("arst_timeout", {31'd0, timeout}, 32'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_grant", {30'd0, grant}, 32'd1);
    check("post_rst_sel",   {31'd0, sel},   32'd0);

    cyc(2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 2'b00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
